// File: rtl/pipe_drain_ctrl.sv
// Output-side valid/last tracker for the fixed-latency AES round pipeline:
// reports block exit, message end, in-flight count and drain status.
module pipe_drain_ctrl #(
    parameter int unsigned LATENCY  = 30,
    parameter int unsigned CNT_BITS = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pipe_en,
    input  logic                i_flush,
    input  logic                i_in_valid,
    input  logic                i_in_last,
    output logic                o_out_valid,
    output logic                o_out_last,
    output logic [CNT_BITS-1:0] o_inflight,
    output logic                o_drained,
    output logic                o_msg_done
);

    logic [LATENCY-1:0]  r_vsr;
    logic [LATENCY-1:0]  r_lsr;
    logic [CNT_BITS-1:0] r_inflight;
    logic                r_msg_done;

    logic                w_accept;
    logic                w_exit;
    logic [LATENCY-1:0]  w_vsr_next;
    logic [LATENCY-1:0]  w_lsr_next;

    assign w_accept = i_in_valid & i_pipe_en & ~i_flush;
    assign w_exit   = o_out_valid & i_pipe_en & ~i_flush;

    generate
        if (LATENCY == 1) begin : g_single
            assign w_vsr_next = w_accept;
            assign w_lsr_next = w_accept & i_in_last;
        end else begin : g_multi
            assign w_vsr_next = {r_vsr[LATENCY-2:0], w_accept};
            assign w_lsr_next = {r_lsr[LATENCY-2:0], w_accept & i_in_last};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_vsr      <= '0;
            r_lsr      <= '0;
            r_inflight <= '0;
            r_msg_done <= 1'b0;
        end else if (i_pipe_en) begin
            r_vsr      <= w_vsr_next;
            r_lsr      <= w_lsr_next;
            r_msg_done <= w_exit & o_out_last;
            // Simultaneous accept and exit leave the count unchanged.
            if (w_accept && !w_exit)
                r_inflight <= r_inflight + CNT_BITS'(1);
            else if (!w_accept && w_exit)
                r_inflight <= r_inflight - CNT_BITS'(1);
        end else begin
            r_msg_done <= 1'b0;
        end
    end

    assign o_out_valid = r_vsr[LATENCY-1];
    assign o_out_last  = r_lsr[LATENCY-1] & r_vsr[LATENCY-1];
    assign o_inflight  = r_inflight;
    assign o_drained   = (r_inflight == '0);
    assign o_msg_done  = r_msg_done;

endmodule

// File: doc/pipe_drain_ctrl.md
# pipe_drain_ctrl

Output-side valid/last tracker for the fixed-latency AES round pipeline. The pipeline fill counter reports when the pipeline is full. This block reports the other end: which cycle a block emerges from the final stage, which block is the last of a message, how many blocks are in flight, and when the pipeline has fully drained. It sits beside the pipeline datapath and drives the output-register load and message-complete logic.

## Interface
- LATENCY, 30, pipeline depth in enabled clock edges from input accept to output; must be ≥ 1.
- CNT_BITS, 6, width of in-flight counter; must satisfy 2^CNT_BITS > LATENCY.
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- pipe_en  input  1  pipeline advance; 0 freezes every stage.
- flush  input  1  synchronous abort; discards all in-flight blocks.
- in_valid  input  1  block presented to stage 0 this cycle.
- in_last  input  1  qualifies in_valid: block is last of message.
- out_valid  output  1  block present at final stage this cycle.
- out_last  output  1  block at final stage is last of message.
- inflight  output  CNT_BITS  number of blocks currently in the pipeline.
- drained  output  1  inflight == 0.
- msg_done  output  1  one-cycle pulse after a last block leaves.

## Operation
- One clock (clk); reset is synchronous and active-high (rst). Priority on each edge: rst > flush > normal operation.
- State: valid shift register vsr[LATENCY-1:0], last shift register lsr[LATENCY-1:0], inflight counter, msg_done register.
- accept = in_valid & pipe_en & ~flush. exit = out_valid & pipe_en & ~flush.
- pipe_en=1, no flush, edge: vsr <= {vsr[LATENCY-2:0], accept}; lsr <= {lsr[LATENCY-2:0], accept & in_last}. For LATENCY=1, vsr <= accept.
- pipe_en=0: vsr, lsr and inflight hold. in_valid is not accepted, and the sender must hold it.
- out_valid = vsr[LATENCY-1]; out_last = lsr[LATENCY-1] & out_valid. Both come directly from registers, with no combinational path from inputs.
- inflight update: +1 on accept, −1 on exit, unchanged when both or neither occur. inflight always equals popcount(vsr) and never exceeds LATENCY.
- drained = (inflight == 0), decoded from the register.
- msg_done <= exit & out_last (registered), so it is high exactly one cycle.
- flush: vsr, lsr, inflight and msg_done clear to 0. An in_valid presented in the same cycle is dropped. A block at the output in the flush cycle is not counted as exiting, and msg_done does not pulse.
- in_last with in_valid=0 is ignored.

## Timing
- Reset values: out_valid 0, out_last 0, inflight 0, drained 1, msg_done 0. Reset takes effect at the first rising edge with rst=1.
- Latency: a block accepted at edge k has out_valid=1 in the cycle after the LATENCY-th enabled edge counting k. With no stalls, that is the cycle after edge k+LATENCY−1.
- Each stall cycle (pipe_en=0) adds exactly one cycle to the latency of every in-flight block.
- inflight reflects an accept or exit in the cycle after the edge. drained follows inflight with no extra delay.
- msg_done is high in the cycle after the edge on which the last block exits.
- Steady state with back-to-back input: inflight reaches LATENCY and then holds, because accept and exit occur in the same cycle.
- Reset or flush mid-message: all tracking is lost. The next accepted block starts a fresh message.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs → out_valid=0, out_last=0, inflight=0, drained=1, msg_done=0.
- Single block, LATENCY=30, pipe_en=1: in_valid=1, in_last=1 for one cycle → out_valid=out_last=1 for exactly one cycle, 30 cycles after the accept cycle. inflight=1 for 30 cycles, then 0. msg_done pulses in the following cycle.
- Back-to-back: 40 consecutive blocks, in_last on the 40th → inflight climbs 1..30 and holds at 30 for 10 cycles. out_valid is continuous for 40 cycles, and out_last coincides with the 40th output. After that, inflight falls to 0, drained=1, and msg_done pulses once.
- Stall: 3 blocks in flight, pipe_en=0 for 5 cycles with in_valid=1 during the stall → in_valid is ignored and inflight stays 3. Each output is delayed by exactly 5 cycles.
- Flush: 10 blocks in flight, flush=1 together with in_valid=1 → next cycle inflight=0, drained=1. No out_valid or msg_done follows for those blocks.
- LATENCY=1 build: continuous in_valid → out_valid follows in_valid by one cycle and inflight holds at 1.
